// File: rtl/sweep_matcher.sv
// sweep_matcher: steps candidates into an equality comparator until it matches or the range runs out.
// SWEEP_DOWN_EN selects a descending sweep starting at all ones.
module sweep_matcher #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             eq,
    output logic [WIDTH-1:0] cand,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] found_val,
    output logic [WIDTH:0]   steps
);
    localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
`ifdef SWEEP_DOWN_EN
    localparam logic [WIDTH-1:0] first = '1, last = '0;
    wire [WIDTH-1:0] next = cand - 1'b1;
`else
    localparam logic [WIDTH-1:0] first = '0, last = '1;
    wire [WIDTH-1:0] next = cand + 1'b1;
`endif
    logic [1:0] state;
    assign busy = state == SCAN;
    assign done = state == DONE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            found     <= 1'b0;
            found_val <= '0;
            steps     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state     <= SCAN;
                    cand      <= first;
                    found     <= 1'b0;
                    found_val <= '0;
                    steps     <= '0;
                end
                SCAN: begin
                    steps <= steps + 1'b1;
                    if (eq) begin
                        state     <= DONE;
                        found     <= 1'b1;
                        found_val <= cand;
                    end else if (cand == last) begin
                        state <= DONE;
                    end else begin
                        cand <= next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sweep_matcher.md
Name: sweep_matcher

Overview:
- Sequential driver for the team's 4-bit equality comparator: drives candidate values onto the comparator's a input and consumes its equality result.
- The comparator's b input is tied to a target elsewhere. On start, the block sweeps candidates one per clock until the comparator reports a match or the range is exhausted.
- Reports the matching value and the number of candidates tried.
- Sits between control logic (lock/guess/search FSMs) and a comparator instance.

Parameters:
WIDTH, 4, width of candidate and target values; the comparator instance must match.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a sweep; sampled only in IDLE
eq  input  1  equality result from comparator (1 = cand equals target); combinational from cand
cand  output  WIDTH  candidate value driven to comparator a input; registered
busy  output  1  high while sweeping (SCAN state)
done  output  1  one-cycle pulse when a sweep ends
found  output  1  last sweep ended in a match; holds until next start
found_val  output  WIDTH  matching candidate of last successful sweep; holds until next start
steps  output  WIDTH+1  candidates compared in last sweep (1..2^WIDTH); holds until next start

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-high.
- Reset values: state=IDLE; cand=0, busy=0, done=0, found=0, found_val=0, steps=0.
- States: IDLE, SCAN, DONE. All outputs are registered. busy=1 only in SCAN; done=1 only in DONE.
- IDLE:
  - start=1 at a clock edge -> SCAN. Same edge: cand<=first candidate (0), found<=0, found_val<=0, steps<=0.
  - eq is ignored in IDLE.
  - start=0 -> stay in IDLE; cand holds its value.
- SCAN: eq is sampled each edge, evaluated against the current cand. steps<=steps+1 on every SCAN edge.
  - eq=1 -> DONE; found<=1, found_val<=cand; cand holds.
  - eq=0 and cand is the last candidate (all ones) -> DONE; found stays 0; cand holds.
  - eq=0 otherwise -> stay in SCAN; cand<=cand+1.
- DONE: one cycle, then unconditionally IDLE. start during DONE is ignored and not queued.
- Latency: match on the k-th candidate (cand=k-1) -> done is high in cycle k+1 after the start edge, with steps=k.
  - No-match sweep: steps=2^WIDTH.
- cand never wraps: the increment is suppressed at all-ones, so steps never exceeds 2^WIDTH.
- start while busy: ignored; the sweep continues unaffected.
- Reset mid-sweep: immediate return to the reset values. No done pulse; prior results are lost.
- eq is assumed valid in the same cycle as cand (comparator is purely combinational). No internal synchronisation of eq.

Optional Feature:
- Macro SWEEP_DOWN_EN.
- Defined:
  - First candidate is all ones.
  - SCAN decrements cand.
  - Exhaustion is detected at cand=0 with eq=0.
  - steps counting, found and found_val semantics are unchanged.
- Undefined: ascending sweep from 0 as described above.
- The port list is identical in both builds.

Test Plan:
- Test setup (all scenarios): WIDTH=4; the bench models the comparator as eq = (cand == target).
- Reset: assert reset asynchronously mid-cycle -> cand=0, busy=0, done=0, found=0, found_val=0, steps=0 immediately.
- Match mid-range: target=5, pulse start one cycle in IDLE.
  - Expect busy for 6 cycles with cand 0,1,2,3,4,5.
  - Then done for 1 cycle with found=1, found_val=5, steps=6.
  - Back in IDLE, results hold.
- Match first candidate: target=0, start -> done after 1 SCAN cycle; found=1, found_val=0, steps=1.
- No match: bench forces eq=0 always, start.
  - Expect cand 0..15, busy 16 cycles.
  - Then done with found=0, found_val=0, steps=16, cand=15.
- Protocol corners:
  - start held high through a sweep (target=3) -> single sweep, done once, steps=4, then a new sweep begins from IDLE.
  - Separate run, target=9: reset asserted when cand=6 -> IDLE and reset values, no done pulse.
- SWEEP_DOWN_EN build: target=5, start.
  - Expect cand 15,14,...,5.
  - Then done with found=1, found_val=5, steps=11.
  - With eq forced 0: steps=16, cand=0.
